sandbox_host_bridge: RTL and testbench

- Host-side counterpart of the sandbox process handshake.
- Assembles 5-byte command frames from the host byte stream (UART receiver side) and presents them as control/inputData with a dataReceived flag; retires the flag on clearDR.
- On a rising transmitData, captures status/outputData and serialises them as a 5-byte response frame to the host byte transmitter.
- Sits between the UART byte interfaces and the sandbox process.

---
 rtl/sandbox_host_bridge_pkg.sv | 30 +++
 rtl/sandbox_host_bridge_if.sv | 28 ++
 rtl/sandbox_host_bridge_frame_tx.sv | 58 +++++
 rtl/sandbox_host_bridge.sv | 113 +++++++++++
 tb/tb_sandbox_host_bridge.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sandbox_host_bridge_pkg.sv
// rtl/sandbox_host_bridge_pkg.sv - frame constants, tx state type and byte-order helpers for the host bridge
package sandbox_bridge_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int FRAME_W     = FRAME_BYTES * 8;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Wire order of a response frame: status first, then the result word MSB first.
  localparam int BYTE_STATUS     = 0;
  localparam int BYTE_DATA_FIRST = 1;

  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame, input int idx);
    return frame[FRAME_W-1-8*idx -: 8];
  endfunction

  function automatic logic [FRAME_W-1:0] pack_response(input logic [7:0] st, input logic [31:0] data);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_W-1-8*BYTE_STATUS -: 8] = st;
    for (int i = 0; i < 4; i++) begin
      f[FRAME_W-1-8*(BYTE_DATA_FIRST+i) -: 8] = data[31-8*i -: 8];
    end
    return f;
  endfunction

endpackage

// File: rtl/sandbox_host_bridge_if.sv
// rtl/sandbox_host_bridge_if.sv - host byte streams and sandbox handshake bundle for the host bridge
interface sandbox_host_bridge_if;
  logic        rxByteValid;
  logic [7:0]  rxByte;
  logic        txByteReady;
  logic        txByteValid;
  logic [7:0]  txByte;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        clearDR;
  logic        transmitData;
  logic [7:0]  status;
  logic [31:0] outputData;
  logic        frameError;
  logic        rxOverrun;
  logic        txDropped;

  modport slave (
    input  rxByteValid, rxByte, txByteReady, clearDR, transmitData, status, outputData,
    output txByteValid, txByte, dataReceived, control, inputData, frameError, rxOverrun, txDropped
  );

  modport master (
    output rxByteValid, rxByte, txByteReady, clearDR, transmitData, status, outputData,
    input  txByteValid, txByte, dataReceived, control, inputData, frameError, rxOverrun, txDropped
  );
endinterface

// File: rtl/sandbox_host_bridge_frame_tx.sv
// rtl/sandbox_host_bridge_frame_tx.sv - 5-byte response serialiser with valid/ready byte handshake
module sandbox_frame_tx
  import sandbox_bridge_pkg::*;
(
  input  logic               masterClock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] load_frame_i,
  output logic               busy_o,
  output logic [7:0]         tx_tdata_o,
  output logic               tx_tvalid_o,
  input  logic               tx_tready_i
);

  localparam logic [0:0] ST_IDLE = TX_IDLE;
  localparam logic [0:0] ST_SEND = TX_SEND;

  logic [0:0]         state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [2:0]         left_q, left_d;

  // Loads are only honoured in IDLE; the top reports an ignored request as txDropped.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    left_d  = left_q;
    if (state_q == ST_IDLE) begin
      if (load_i) begin
        shift_d = load_frame_i;
        left_d  = 3'(FRAME_BYTES);
        state_d = ST_SEND;
      end
    end else if (tx_tready_i) begin
      shift_d = {shift_q[FRAME_W-9:0], 8'h00};
      left_d  = left_q - 3'd1;
      if (left_q == 3'd1) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      left_q  <= left_d;
    end
  end

  assign busy_o      = (state_q == ST_SEND);
  assign tx_tvalid_o = (state_q == ST_SEND);
  assign tx_tdata_o  = frame_byte(shift_q, BYTE_STATUS);

endmodule

// File: rtl/sandbox_host_bridge.sv
// rtl/sandbox_host_bridge.sv - host-side command frame assembler and response frame sender for the sandbox
module sandbox_host_bridge
  import sandbox_bridge_pkg::*;
#(
  parameter int GAP_TIMEOUT = 1000000,
  localparam int CNT_W = $clog2(GAP_TIMEOUT + 1)
) (
  input logic                 masterClock,
  input logic                 reset,
  sandbox_host_bridge_if.slave bus
);

  logic [2:0]       rx_cnt_q, rx_cnt_d;
  logic [31:0]      rx_stage_q, rx_stage_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             dr_q, dr_d;
  logic [7:0]       control_q, control_d;
  logic [31:0]      input_data_q, input_data_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             dropped_q, dropped_d;
  logic             td_q;

  logic             rx_accept;
  logic             tx_edge;
  logic             tx_busy;

  assign rx_accept = bus.rxByteValid & ~dr_q;
  assign tx_edge   = bus.transmitData & ~td_q;

  // Partial frames live in rx_stage_q so control/inputData only move when a frame completes.
  always_comb begin
    rx_cnt_d     = rx_cnt_q;
    rx_stage_d   = rx_stage_q;
    gap_d        = gap_q;
    dr_d         = dr_q;
    control_d    = control_q;
    input_data_d = input_data_q;
    frame_err_d  = 1'b0;
    overrun_d    = bus.rxByteValid & dr_q;
    dropped_d    = tx_edge & tx_busy;

    if (rx_accept) begin
      gap_d = '0;
      if (rx_cnt_q == 3'(FRAME_BYTES - 1)) begin
        control_d    = rx_stage_q[31:24];
        input_data_d = {rx_stage_q[23:0], bus.rxByte};
        rx_cnt_d     = 3'd0;
        dr_d         = 1'b1;
      end else begin
        rx_stage_d = {rx_stage_q[23:0], bus.rxByte};
        rx_cnt_d   = rx_cnt_q + 3'd1;
      end
    end else if (rx_cnt_q != 3'd0) begin
      if (gap_q == CNT_W'(GAP_TIMEOUT - 1)) begin
        rx_cnt_d    = 3'd0;
        gap_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        gap_d = gap_q + CNT_W'(1);
      end
    end

    if (bus.clearDR & dr_q) begin
      dr_d = 1'b0;
    end
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      rx_cnt_q     <= '0;
      rx_stage_q   <= '0;
      gap_q        <= '0;
      dr_q         <= 1'b0;
      control_q    <= '0;
      input_data_q <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      dropped_q    <= 1'b0;
      td_q         <= 1'b0;
    end else begin
      rx_cnt_q     <= rx_cnt_d;
      rx_stage_q   <= rx_stage_d;
      gap_q        <= gap_d;
      dr_q         <= dr_d;
      control_q    <= control_d;
      input_data_q <= input_data_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      dropped_q    <= dropped_d;
      td_q         <= bus.transmitData;
    end
  end

  sandbox_frame_tx u_frame_tx (
    .masterClock  (masterClock),
    .reset        (reset),
    .load_i       (tx_edge),
    .load_frame_i (pack_response(bus.status, bus.outputData)),
    .busy_o       (tx_busy),
    .tx_tdata_o   (bus.txByte),
    .tx_tvalid_o  (bus.txByteValid),
    .tx_tready_i  (bus.txByteReady)
  );

  assign bus.dataReceived = dr_q;
  assign bus.control      = control_q;
  assign bus.inputData    = input_data_q;
  assign bus.frameError   = frame_err_q;
  assign bus.rxOverrun    = overrun_q;
  assign bus.txDropped    = dropped_q;

endmodule

// File: tb/tb_sandbox_host_bridge.sv
// tb/tb_sandbox_host_bridge.sv - scoreboard bench for the sandbox host bridge with a queue-based reference model
module tb_sandbox_host_bridge;

  localparam int GAP = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sandbox_host_bridge_if bus();

  sandbox_host_bridge #(.GAP_TIMEOUT(GAP)) dut (
    .masterClock (clk),
    .reset       (reset),
    .bus         (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  logic [7:0]  m_part[$];
  int          m_idle = 0;
  bit          m_dr = 0;
  logic [39:0] m_last = '0;
  int          m_pending = 0;
  bit          m_td_prev = 0;
  int          e_ferr = 0, e_ovr = 0, e_drop = 0;

  // Scoreboard queues
  logic [7:0]  exp_tx[$];
  int          exp_tcyc[$];
  logic [39:0] exp_frame[$];
  int          exp_fcyc[$];

  // Monitor observations
  int          o_ferr = 0, o_ovr = 0, o_drop = 0;
  logic        prev_dr = 1'b0, prev_valid = 1'b0, stalled = 1'b0;
  logic [7:0]  stall_byte = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pulses, frame completion, tx bytes, tx stability and latency.
  always @(negedge clk) begin
    if (bus.frameError === 1'b1) o_ferr++;
    if (bus.rxOverrun  === 1'b1) o_ovr++;
    if (bus.txDropped  === 1'b1) o_drop++;

    if (bus.dataReceived === 1'b1 && prev_dr !== 1'b1) begin
      if (exp_frame.size() == 0) begin
        chk("unexpected_frame", 1, 0);
      end else begin
        chk("rx_frame", {bus.control, bus.inputData}, exp_frame.pop_front());
        chk("rx_frame_latency", cyc, exp_fcyc.pop_front());
      end
    end
    prev_dr = bus.dataReceived;

    if (bus.txByteValid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_tcyc.size() == 0) chk("unexpected_tx_start", 1, 0);
      else chk("tx_first_latency", cyc, exp_tcyc.pop_front());
    end
    prev_valid = bus.txByteValid;

    if (reset !== 1'b1) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("tx_hold_valid", bus.txByteValid, 1);
        chk("tx_hold_byte", bus.txByte, stall_byte);
      end
      stalled    = (bus.txByteValid === 1'b1) && (bus.txByteReady === 1'b0);
      stall_byte = bus.txByte;
    end

    if (bus.txByteValid === 1'b1 && bus.txByteReady === 1'b1) begin
      if (exp_tx.size() == 0) chk("unexpected_tx_byte", bus.txByte, 0);
      else chk("tx_byte", bus.txByte, exp_tx.pop_front());
    end
  end

  // One clock of stimulus; the model consumes exactly what the DUT samples at this edge.
  task automatic cycle(input bit rv, input logic [7:0] rb, input bit clr, input bit td, input bit rdy);
    bit dr_before;
    bit busy;
    bus.rxByteValid  = rv;
    bus.rxByte       = rb;
    bus.clearDR      = clr;
    bus.transmitData = td;
    bus.txByteReady  = rdy;

    dr_before = m_dr;
    if (rv && dr_before) begin
      e_ovr++;
    end else if (rv) begin
      m_part.push_back(rb);
      m_idle = 0;
      if (m_part.size() == 5) begin
        m_last = {m_part[0], m_part[1], m_part[2], m_part[3], m_part[4]};
        exp_frame.push_back(m_last);
        exp_fcyc.push_back(cyc + 1);
        m_part.delete();
        m_dr = 1;
      end
    end else if (m_part.size() > 0) begin
      m_idle++;
      if (m_idle == GAP) begin
        m_part.delete();
        m_idle = 0;
        e_ferr++;
      end
    end
    if (clr && dr_before) m_dr = 0;

    busy = (m_pending > 0);
    if (busy && rdy) m_pending--;
    if (td && !m_td_prev) begin
      if (busy) begin
        e_drop++;
      end else begin
        exp_tx.push_back(bus.status);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(bus.outputData[8*i +: 8]);
        exp_tcyc.push_back(cyc + 1);
        m_pending = 5;
      end
    end
    m_td_prev = td;

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, rdy);
  endtask

  task automatic do_reset(input int n);
    reset            = 1'b0;
    bus.rxByteValid  = 0;
    bus.rxByte       = 0;
    bus.clearDR      = 0;
    bus.transmitData = 0;
    bus.txByteReady  = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_dataReceived", bus.dataReceived, 0);
    chk("rst_control", bus.control, 0);
    chk("rst_inputData", bus.inputData, 0);
    chk("rst_txByteValid", bus.txByteValid, 0);
    chk("rst_txByte", bus.txByte, 0);
    chk("rst_pulses", {bus.frameError, bus.rxOverrun, bus.txDropped}, 0);
    m_part.delete();
    m_idle = 0; m_dr = 0; m_last = '0; m_pending = 0; m_td_prev = 0;
    exp_tx.delete(); exp_tcyc.delete(); exp_frame.delete(); exp_fcyc.delete();
    reset = 1'b1;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_dataReceived"}, bus.dataReceived, m_dr);
    chk({tag, "_cmd"}, {bus.control, bus.inputData}, m_last);
    chk({tag, "_frameError_cnt"}, o_ferr, e_ferr);
    chk({tag, "_rxOverrun_cnt"}, o_ovr, e_ovr);
    chk({tag, "_txDropped_cnt"}, o_drop, e_drop);
  endtask

  task automatic send_frame(input logic [39:0] f, input int gap);
    logic [39:0] v;
    v = f;
    for (int i = 4; i >= 0; i--) begin
      cycle(1, v[8*i +: 8], 0, 0, 1);
      if (i != 0) idle(gap, 1);
    end
  endtask

  task automatic send_response(input logic [7:0] st, input logic [31:0] d);
    bus.status     = st;
    bus.outputData = d;
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 0, 1, 1);
    idle(2, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.status = 0;
    bus.outputData = 0;
    do_reset(2);

    // Command frame then a two-cycle clearDR
    send_frame(40'h01_DEADBEEF, 2);
    check_all("frame1");
    cycle(0, 8'h00, 1, 0, 1);
    cycle(0, 8'h00, 1, 0, 1);
    check_all("clear");

    // Overrun, including the byte that arrives alongside clearDR
    send_frame(40'hA5_11223344, 0);
    cycle(1, 8'h55, 0, 0, 1);
    check_all("overrun");
    cycle(1, 8'h66, 1, 0, 1);
    check_all("overrun_clear");

    // Gap timeout on a partial frame, then a fresh frame
    cycle(1, 8'h77, 0, 0, 1);
    cycle(1, 8'h88, 0, 0, 1);
    idle(GAP, 1);
    check_all("timeout");
    send_frame(40'h00_0000002A, 1);
    check_all("frame2");
    cycle(0, 8'h00, 1, 0, 1);

    // Response with ready held high
    send_response(8'h03, 32'h12345678);
    check_all("tx1");
    chk("tx1_drained", exp_tx.size(), 0);

    // Ready toggling, with a second request while busy
    bus.status = 8'h03;
    bus.outputData = 32'h12345678;
    for (int i = 0; i < 14; i++) cycle(0, 8'h00, 0, (i != 4), i[0]);
    idle(3, 1);
    check_all("tx2");
    chk("tx2_drained", exp_tx.size(), 0);

    // Reset in the middle of both a tx frame and an rx frame
    bus.status = 8'hC3;
    bus.outputData = 32'hCAFEF00D;
    cycle(1, 8'h10, 0, 1, 1);
    cycle(1, 8'h20, 0, 1, 1);
    cycle(1, 8'h30, 0, 1, 1);
    do_reset(1);
    send_frame(40'h01_DEADBEEF, 2);
    check_all("post_rst_frame");
    cycle(0, 8'h00, 1, 0, 1);
    send_response(8'h03, 32'h12345678);
    check_all("post_rst_tx");

    // Randomised traffic on both paths
    for (int i = 0; i < 800; i++) begin
      bus.status = 8'($urandom);
      bus.outputData = $urandom;
      cycle(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0,
            (($urandom % 6) == 0) ? !m_td_prev : m_td_prev, $urandom % 2);
    end
    for (int i = 0; i < 30; i++) cycle(0, 8'h00, 1, 0, 1);
    check_all("random");
    chk("random_tx_left", exp_tx.size(), 0);
    chk("random_frames_left", exp_frame.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
